lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Handshake sequencer directly upstream of the LSU datapath in exu. Accepts one decoded instruction from the EXU side (valid/ready),
//  drives the LSU's AR/R or AW/W/B channels as AXI-lite master, captures the load result and response, then hands the result to WBU.
//  Non-memory instructions pass through with no bus activity. One instruction in flight; no reordering.
// PARAMETERS
//  DATA_W       32   width of mem_result_i/o
//  RESP_W       32   width of rresp_i/bresp_i
//  TIMEOUT_CYC  255  bus-wait limit in cycles (used only with LSU_TIMEOUT_EN), 1..2^16-1
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active-low
//  valid_pre_i   in   1       instruction valid from EXU
//  ready_pre_o   out  1       ready to accept; high only in IDLE
//  is_load_i     in   1       instruction is a load (sampled at accept)
//  is_store_i    in   1       instruction is a store (sampled at accept)
//  arvalid_o/arready_i, rvalid_i/rready_o, awvalid_o/awready_i, wvalid_o/wready_i, bvalid_i/bready_o  1 each  LSU channel handshakes
//  rresp_i       in   RESP_W  read response, sampled with rvalid_i&rready_o
//  bresp_i       in   RESP_W  write response, sampled with bvalid_i&bready_o
//  mem_result_i  in   DATA_W  extended load data from LSU, sampled with rvalid_i&rready_o
//  valid_post_o  out  1       result valid to WBU
//  ready_post_i  in   1       WBU ready
//  mem_result_o  out  DATA_W  registered load result (0 for store/non-memory)
//  resp_err_o    out  1       nonzero rresp/bresp or timeout; valid with valid_post_o
//  timeout_o     out  1       wait aborted by watchdog (tied 0 without LSU_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all valid/ready outputs 0 except ready_pre_o=1; mem_result_o=0, resp_err_o=0, timeout_o=0.
//  FSM: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE. All outputs are functions of registered state/flags only.
//  IDLE: on valid_pre_i: load -> RD_ADDR; else store -> WR_REQ; else -> DONE. Load wins if both flags set (resp_err_o unaffected).
//   On accept clear mem_result_o, resp_err_o, timeout_o.
//  RD_ADDR: arvalid_o=1 until arready_i sampled high -> RD_DATA.
//  RD_DATA: rready_o=1; on rvalid_i: mem_result_o<=mem_result_i, resp_err_o<=|rresp_i -> DONE.
//  WR_REQ: awvalid_o and wvalid_o both raised on entry; each drops the cycle after its own handshake (aw_done/w_done flags);
//   both handshakes in one cycle legal; when both done -> WR_RESP. Valid never drops before its handshake.
//  WR_RESP: bready_o=1; on bvalid_i: resp_err_o<=|bresp_i -> DONE.
//  DONE: valid_post_o=1, outputs held stable until ready_post_i -> IDLE. No accept in the same cycle (ready_pre_o=0 in DONE).
//  Latency (zero-wait slave): non-mem accept->valid_post 1 cycle; load 3 cycles; store 3 cycles. Min issue interval 2 cycles.
//  Inputs other than handshakes are ignored outside their sampling cycle; is_*_i need not be held after accept.
//  Reset mid-transaction: immediate return to IDLE, all valids drop; in-flight bus beat is abandoned.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined: watchdog counts cycles spent in RD_ADDR/RD_DATA/WR_REQ/WR_RESP, cleared on entering each of those
//   states from IDLE; reaching TIMEOUT_CYC forces DONE with mem_result_o=0, resp_err_o=1, timeout_o=1 (debug escape; AXI rule waived).
//  LSU_TIMEOUT_EN undefined: no counter, waits indefinitely, timeout_o tied 0.
// STRUCTURE
//  defines.v: LSU_CTRL_STATE_BUS width and `LSU_ST_IDLE..`LSU_ST_DONE encodings, default TIMEOUT_CYC.
//  Sub-module lsu_watchdog (counter, clr/en in, expire out), instantiated only under LSU_TIMEOUT_EN.
// TESTING
//  1 non-mem: valid_pre_i=1, is_load=is_store=0, ready_post_i=1 -> valid_post_o 1 cycle later, mem_result_o=0, no bus valids.
//  2 load, arready delayed 3 cycles, rvalid with mem_result_i=32'hDEAD_BEEF, rresp=0 -> arvalid held 4 cycles, mem_result_o=DEADBEEF, resp_err_o=0.
//  3 store, wready 2 cycles before awready, bresp=32'h2 -> wvalid drops first, awvalid holds, then bready; resp_err_o=1.
//  4 backpressure: ready_post_i=0 for 5 cycles in DONE -> valid_post_o/mem_result_o stable, ready_pre_o=0, new valid_pre_i not taken.
//  5 rst pulled low in RD_DATA -> next edge-independent: rready_o=0, ready_pre_o=1; following load completes normally.
//  6 LSU_TIMEOUT_EN, TIMEOUT_CYC=8, arready_i stuck 0 -> DONE after 8 cycles, timeout_o=1, resp_err_o=1, mem_result_o=0.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// Shared state encoding and defaults for the LSU handshake sequencer.
// Optional watchdog is enabled with the LSU_TIMEOUT_EN macro.
package lsu_ctrl_pkg;

    localparam int LSU_CTRL_STATE_W    = 3;
    localparam int LSU_TIMEOUT_CYC_DEF = 255;
    localparam int LSU_WDOG_W          = 16;

    typedef enum logic [LSU_CTRL_STATE_W-1:0] {
        LSU_ST_IDLE    = 3'd0,
        LSU_ST_RD_ADDR = 3'd1,
        LSU_ST_RD_DATA = 3'd2,
        LSU_ST_WR_REQ  = 3'd3,
        LSU_ST_WR_RESP = 3'd4,
        LSU_ST_DONE    = 3'd5
    } lsu_state_e;

    function automatic logic lsu_busy(input lsu_state_e s);
        return (s == LSU_ST_RD_ADDR) || (s == LSU_ST_RD_DATA) ||
               (s == LSU_ST_WR_REQ)  || (s == LSU_ST_WR_RESP);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// AXI-lite style handshake bundle between the sequencer and the LSU.
// master = sequencer side, slave = LSU datapath side.
interface lsu_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int RESP_W = 32
);
    logic              arvalid;
    logic              arready;
    logic              rvalid;
    logic              rready;
    logic [RESP_W-1:0] rresp;
    logic [DATA_W-1:0] mem_result;
    logic              awvalid;
    logic              awready;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic              bready;
    logic [RESP_W-1:0] bresp;

    modport master (
        output arvalid, rready, awvalid, wvalid, bready,
        input  arready, rvalid, rresp, mem_result,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, rready, awvalid, wvalid, bready,
        output arready, rvalid, rresp, mem_result,
        output awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/lsu_ctrl_watchdog.sv
// Bus-wait watchdog: counts enabled cycles, flags the cycle the limit is hit.
// Only instantiated when LSU_TIMEOUT_EN is defined.
module lsu_watchdog
    import lsu_ctrl_pkg::*;
#(
    parameter int LIMIT = LSU_TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam logic [LSU_WDOG_W-1:0] LAST = LSU_WDOG_W'(LIMIT - 1);

    logic [LSU_WDOG_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // fires during the LIMIT-th busy cycle so DONE follows exactly LIMIT cycles in
    assign expire = en & (cnt == LAST);
endmodule

// File: rtl/lsu_ctrl.sv
// Handshake sequencer between EXU, the LSU bus channels and WBU.
// Define LSU_TIMEOUT_EN to add a bus-wait watchdog (timeout_o).
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int RESP_W      = 32,
    parameter int TIMEOUT_CYC = LSU_TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_pre_i,
    output logic              ready_pre_o,
    input  logic              is_load_i,
    input  logic              is_store_i,
    lsu_ctrl_if.master        bus,
    output logic              valid_post_o,
    input  logic              ready_post_i,
    output logic [DATA_W-1:0] mem_result_o,
    output logic              resp_err_o,
    output logic              timeout_o
);
    lsu_state_e        state;
    lsu_state_e        state_nxt;
    logic              aw_done;
    logic              w_done;
    logic [DATA_W-1:0] result_q;
    logic              err_q;
    logic              accept;
    logic              ar_hs;
    logic              r_hs;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              wr_fin;
    logic              expire;

    assign accept = (state == LSU_ST_IDLE) & valid_pre_i;
    assign ar_hs  = bus.arvalid & bus.arready;
    assign r_hs   = bus.rvalid & bus.rready;
    assign aw_hs  = bus.awvalid & bus.awready;
    assign w_hs   = bus.wvalid & bus.wready;
    assign b_hs   = bus.bvalid & bus.bready;
    assign wr_fin = (aw_done | aw_hs) & (w_done | w_hs);

`ifdef LSU_TIMEOUT_EN
    logic busy;
    logic to_q;

    assign busy = lsu_busy(state);

    lsu_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (busy),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_q <= 1'b0;
        end else if (accept) begin
            to_q <= 1'b0;
        end else if (expire) begin
            to_q <= 1'b1;
        end
    end

    assign timeout_o = to_q;
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LSU_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            LSU_ST_IDLE: begin
                if (valid_pre_i) begin
                    unique case (1'b1)
                        is_load_i:
                            state_nxt = LSU_ST_RD_ADDR;
                        !is_load_i & is_store_i:
                            state_nxt = LSU_ST_WR_REQ;
                        !is_load_i & !is_store_i:
                            state_nxt = LSU_ST_DONE;
                        default:
                            state_nxt = LSU_ST_DONE;
                    endcase
                end
            end
            LSU_ST_RD_ADDR: if (ar_hs)  state_nxt = LSU_ST_RD_DATA;
            LSU_ST_RD_DATA: if (r_hs)   state_nxt = LSU_ST_DONE;
            LSU_ST_WR_REQ:  if (wr_fin) state_nxt = LSU_ST_WR_RESP;
            LSU_ST_WR_RESP: if (b_hs)   state_nxt = LSU_ST_DONE;
            LSU_ST_DONE:    if (ready_post_i) state_nxt = LSU_ST_IDLE;
            default:        state_nxt = LSU_ST_IDLE;
        endcase
        if (expire) begin
            state_nxt = LSU_ST_DONE;
        end
    end

    always_comb begin
        ready_pre_o  = 1'b0;
        valid_post_o = 1'b0;
        bus.arvalid  = 1'b0;
        bus.rready   = 1'b0;
        bus.awvalid  = 1'b0;
        bus.wvalid   = 1'b0;
        bus.bready   = 1'b0;
        unique case (state)
            LSU_ST_IDLE:    ready_pre_o = 1'b1;
            LSU_ST_RD_ADDR: bus.arvalid = 1'b1;
            LSU_ST_RD_DATA: bus.rready  = 1'b1;
            LSU_ST_WR_REQ: begin
                bus.awvalid = !aw_done;
                bus.wvalid  = !w_done;
            end
            LSU_ST_WR_RESP: bus.bready   = 1'b1;
            LSU_ST_DONE:    valid_post_o = 1'b1;
            default:        ;
        endcase
    end

    // a watchdog abort discards any beat that lands in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
            err_q    <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else if (accept) begin
            result_q <= '0;
            err_q    <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else if (expire) begin
            result_q <= '0;
            err_q    <= 1'b1;
        end else begin
            if (r_hs) begin
                result_q <= bus.mem_result;
                err_q    <= |bus.rresp;
            end
            if (b_hs) begin
                err_q <= |bus.bresp;
            end
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done <= 1'b1;
            end
        end
    end

    assign mem_result_o = result_q;
    assign resp_err_o   = err_q;
endmodule
